seg7_shift_out: RTL and testbench
=================================

Name: seg7_shift_out

Overview:
- Downstream stage of the machine controller.
- Consumes the controller's 7-bit segment pattern plus a decimal point.
- Serialises each frame to an external 74HC595-style shift register using data, clock and latch pins, so the display needs only 3 output pins.
- Sends a frame whenever the pattern changes, and also re-sends periodically to recover from glitches on the external register.

Parameters:
- CLK_DIV, default 4: clk cycles per ser_clk half-period; legal range ≥1.
- REFRESH, default 1000: idle clk cycles before an unchanged frame is re-sent; 0 disables refresh.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- segments  in  7  segment pattern from the controller, bit 6 = seg g … bit 0 = seg a
- dp  in  1  decimal point
- ser_data  out  1  serial data to the external register, MSB first
- ser_clk  out  1  shift clock; the external register samples ser_data on its rising edge
- ser_latch  out  1  storage-register latch pulse, active-high
- busy  out  1  high while a frame transfer is in progress

Behaviour:
- Frame format: frame = {dp, segments}, 8 bits. Shift order is dp, seg[6] … seg[0].
- Reset (asynchronous, any state):
  - state = IDLE.
  - ser_data, ser_clk, ser_latch and busy all = 0.
  - Shift register, bit counter, divider and refresh counter all = 0.
  - sent_valid = 0, last_sent = 0.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE:
  - Each cycle, evaluate trigger = !sent_valid OR frame != last_sent OR (REFRESH != 0 AND refresh_cnt == REFRESH-1).
  - On trigger at edge N: shreg ← frame, bitcnt ← 0, div ← 0, go to SHIFT_LO, refresh_cnt ← 0.
  - Otherwise refresh_cnt increments, saturating at REFRESH-1.
- SHIFT_LO:
  - ser_clk = 0, ser_data = shreg[7], busy = 1.
  - After CLK_DIV cycles, go to SHIFT_HI.
- SHIFT_HI:
  - ser_clk = 1, ser_data held at the same bit.
  - After CLK_DIV cycles, shreg shifts left by 1 and bitcnt increments.
  - If bitcnt was 7, go to LATCH; else go to SHIFT_LO.
- LATCH:
  - ser_clk = 0, ser_latch = 1, ser_data = 0.
  - After CLK_DIV cycles, last_sent ← captured frame, sent_valid ← 1, go to IDLE.
- Timing:
  - busy is high from edge N+1 for exactly 17·CLK_DIV cycles (68 at default).
  - The first ser_clk rise occurs CLK_DIV cycles after edge N.
  - 8 ser_clk rising edges and 1 latch pulse per frame.
- Outputs are registered (Moore). The ser_data change occurs only while ser_clk is low, giving a CLK_DIV-cycle setup margin.
- Input changes during a transfer are ignored for that frame. The next IDLE cycle compares the live frame against last_sent, so the latest value is sent next and no intermediate frames are queued.
- The first frame after reset is always sent, even when frame == 0, because sent_valid = 0.
- The refresh counter runs only in IDLE; it does not count during a transfer.
- A change and a refresh expiring in the same cycle produce a single transfer.
- Reset mid-transfer aborts immediately with ser_clk and ser_latch low. The partial frame is not latched externally, and the post-reset frame is re-sent.
- Counter widths: div is $clog2(CLK_DIV+1) bits; refresh_cnt is $clog2(REFRESH+1) bits, minimum 1.

Decomposition:
- seg7_pkg:
  - state enum {IDLE, SHIFT_LO, SHIFT_HI, LATCH}
  - FRAME_W = 8
  - SEG_W = 7
- Sub-module seg7_tick_div: parameterised CLK_DIV down-counter with clear and a terminal-count output. It is shared by the SHIFT_LO, SHIFT_HI and LATCH dwell timing.
- The FSM, shift register and refresh logic stay in seg7_shift_out.

Test Plan:
1. Reset release with segments=0, dp=0, CLK_DIV=4 → transfer starts at the first cycle: busy high for 68 cycles, 8 ser_clk rises all sampling 0, one 4-cycle latch pulse, then busy=0.
2. Idle, then segments=7'b0111111, dp=1 → bits sampled on ser_clk rises = 1,0,1,1,1,1,1,1; ser_latch pulses once after the 8th rise; no further transfer while the input is stable and REFRESH is not reached.
3. Change segments to 7'h06 mid-transfer (during bit 3) → the current frame completes unchanged; the next frame 8'h06 starts on the first IDLE cycle after the latch.
4. REFRESH=20 with stable input → re-transfer of the identical frame begins 20 idle cycles after the previous busy fall; repeats periodically.
5. Assert rst during SHIFT_HI of bit 5 → all outputs 0 within the same cycle (asynchronous); after release, the full frame is re-sent from bit 0 with 8 clocks and 1 latch.
6. CLK_DIV=1 → busy lasts 17 cycles; ser_clk alternates low/high every cycle; serial data still matches the frame.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and widths for the 7-segment serial output stage.
// Frame layout is {dp, segments}, shifted MSB first.
package seg7_pkg;

    localparam int FRAME_W = 8;
    localparam int SEG_W   = 7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_e;

endpackage

// File: rtl/seg7_tick_div.sv
// Dwell timer for the serialiser: tc_o pulses on the last of every CLK_DIV cycles.
// Held at zero while clr_i is high, so the first dwell after a clear is exactly CLK_DIV cycles.
module seg7_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tc_o
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tc_o = !clr_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg7_shift_out.sv
// Serialises {dp, segments} into a 74HC595-style register over data/clock/latch pins.
// Sends on change and re-sends an unchanged frame after REFRESH idle cycles.
module seg7_shift_out
    import seg7_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int REFRESH = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEG_W-1:0] segments,
    input  logic             dp,
    output logic             ser_data,
    output logic             ser_clk,
    output logic             ser_latch,
    output logic             busy
);

    localparam int REF_W     = (REFRESH > 0) ? $clog2(REFRESH + 1) : 1;
    localparam int REF_MAX_I = (REFRESH > 0) ? (REFRESH - 1) : 0;
    localparam logic [REF_W-1:0] REF_MAX = REF_W'(REF_MAX_I);

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   shreg_q, shreg_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [FRAME_W-1:0]   last_q, last_d;
    logic                 sent_valid_q, sent_valid_d;
    logic [2:0]           bitcnt_q, bitcnt_d;
    logic [REF_W-1:0]     ref_q, ref_d;
    logic                 ser_data_q, ser_data_d;
    logic                 ser_clk_q, ser_clk_d;
    logic                 ser_latch_q, ser_latch_d;
    logic                 busy_q, busy_d;

    logic [FRAME_W-1:0]   frame;
    logic                 refresh_hit;
    logic                 trigger;
    logic                 div_clr;
    logic                 div_tc;

    assign frame       = {dp, segments};
    assign refresh_hit = (REFRESH != 0) && (ref_q == REF_MAX);
    assign trigger     = !sent_valid_q || (frame != last_q) || refresh_hit;
    assign div_clr     = (state_q == IDLE);

    seg7_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .clr_i (div_clr),
        .tc_o  (div_tc)
    );

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        frame_d      = frame_q;
        last_d       = last_q;
        sent_valid_d = sent_valid_q;
        bitcnt_d     = bitcnt_q;
        ref_d        = ref_q;
        ser_data_d   = ser_data_q;
        ser_clk_d    = ser_clk_q;
        ser_latch_d  = ser_latch_q;
        busy_d       = busy_q;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d     = SHIFT_LO;
                    shreg_d     = frame;
                    frame_d     = frame;
                    bitcnt_d    = 3'd0;
                    ref_d       = '0;
                    ser_data_d  = frame[FRAME_W-1];
                    ser_clk_d   = 1'b0;
                    ser_latch_d = 1'b0;
                    busy_d      = 1'b1;
                end else if (ref_q != REF_MAX) begin
                    ref_d = ref_q + REF_W'(1);
                end
            end
            SHIFT_LO: begin
                if (div_tc) begin
                    state_d   = SHIFT_HI;
                    ser_clk_d = 1'b1;
                end
            end
            SHIFT_HI: begin
                if (div_tc) begin
                    shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
                    bitcnt_d  = bitcnt_q + 3'd1;
                    ser_clk_d = 1'b0;
                    if (bitcnt_q == 3'd7) begin
                        state_d     = LATCH;
                        ser_latch_d = 1'b1;
                        ser_data_d  = 1'b0;
                    end else begin
                        // Next bit is presented on the falling edge, a full dwell before its rise.
                        state_d    = SHIFT_LO;
                        ser_data_d = shreg_q[FRAME_W-2];
                    end
                end
            end
            LATCH: begin
                if (div_tc) begin
                    state_d      = IDLE;
                    last_d       = frame_q;
                    sent_valid_d = 1'b1;
                    ser_latch_d  = 1'b0;
                    busy_d       = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            frame_q      <= '0;
            last_q       <= '0;
            sent_valid_q <= 1'b0;
            bitcnt_q     <= 3'd0;
            ref_q        <= '0;
            ser_data_q   <= 1'b0;
            ser_clk_q    <= 1'b0;
            ser_latch_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            frame_q      <= frame_d;
            last_q       <= last_d;
            sent_valid_q <= sent_valid_d;
            bitcnt_q     <= bitcnt_d;
            ref_q        <= ref_d;
            ser_data_q   <= ser_data_d;
            ser_clk_q    <= ser_clk_d;
            ser_latch_q  <= ser_latch_d;
            busy_q       <= busy_d;
        end
    end

    assign ser_data  = ser_data_q;
    assign ser_clk   = ser_clk_q;
    assign ser_latch = ser_latch_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seg7_shift_out.sv
// Bench for seg7_shift_out: dut_a (CLK_DIV=4, REFRESH=20) and dut_b (CLK_DIV=1, refresh off).
// A monitor decodes each serial frame; the main sequence pops and compares against expectations.
module tb_seg7_shift_out;

  logic clk;
  logic rst_a, rst_b;
  logic [6:0] segments;
  logic dp;
  logic [1:0] o_data, o_clk, o_latch, o_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seg7_shift_out #(.CLK_DIV(4), .REFRESH(20)) dut_a (
    .clk(clk), .rst(rst_a), .segments(segments), .dp(dp),
    .ser_data(o_data[0]), .ser_clk(o_clk[0]), .ser_latch(o_latch[0]), .busy(o_busy[0])
  );

  seg7_shift_out #(.CLK_DIV(1), .REFRESH(0)) dut_b (
    .clk(clk), .rst(rst_b), .segments(segments), .dp(dp),
    .ser_data(o_data[1]), .ser_clk(o_clk[1]), .ser_latch(o_latch[1]), .busy(o_busy[1])
  );

  // scoreboard record: {latch_width[3:0], rising_clk_count[3:0], frame[7:0]}
  logic [15:0] exp_a_q[$];
  logic [15:0] exp_b_q[$];
  logic [15:0] obs_a_q[$];
  logic [15:0] obs_b_q[$];
  int blen_a_q[$];
  int blen_b_q[$];
  int gap_a_q[$];

  int vectors = 0;
  int miscompares = 0;

  // monitor, sampled on the falling clock edge
  logic [1:0] rsts;
  assign rsts = {rst_b, rst_a};
  int m_nbits[2], m_lw[2], m_bn[2], m_gn[2];
  logic [7:0] m_acc[2];
  bit m_hf[2], m_pc[2], m_pl[2], m_pb[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rsts[i]) begin
        m_nbits[i] = 0; m_lw[i] = 0; m_bn[i] = 0; m_gn[i] = 0;
        m_acc[i] = 8'h00; m_hf[i] = 1'b0;
        m_pc[i] = 1'b0; m_pl[i] = 1'b0; m_pb[i] = 1'b0;
      end else begin
        if (o_clk[i] && !m_pc[i]) begin
          m_acc[i] = {m_acc[i][6:0], o_data[i]};
          m_nbits[i]++;
        end
        if (o_latch[i]) m_lw[i]++;
        if (!o_latch[i] && m_pl[i]) begin
          if (i == 0) obs_a_q.push_back({m_lw[i][3:0], m_nbits[i][3:0], m_acc[i]});
          else        obs_b_q.push_back({m_lw[i][3:0], m_nbits[i][3:0], m_acc[i]});
          m_lw[i] = 0;
          m_nbits[i] = 0;
        end
        if (!o_busy[i]) begin
          if (m_pb[i]) begin
            if (i == 0) blen_a_q.push_back(m_bn[i]);
            else        blen_b_q.push_back(m_bn[i]);
            m_bn[i] = 0;
            m_hf[i] = 1'b1;
            m_gn[i] = 0;
          end
          m_gn[i]++;
        end else begin
          if (!m_pb[i] && m_hf[i] && i == 0) gap_a_q.push_back(m_gn[i]);
          m_bn[i]++;
        end
        m_pc[i] = o_clk[i];
        m_pl[i] = o_latch[i];
        m_pb[i] = o_busy[i];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rec(input int lw, input logic [7:0] f);
    return {lw[3:0], 4'd8, f};
  endfunction

  // waits (bounded) for the next decoded frame of one DUT and scores it
  task automatic check_frame(input bit is_b, input int blen);
    int n;
    n = 0;
    while (((is_b ? obs_b_q.size() : obs_a_q.size()) == 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (!is_b) begin
      check("a_frame_arrived", obs_a_q.size() != 0, 1);
      if (obs_a_q.size() != 0 && exp_a_q.size() != 0 && blen_a_q.size() != 0) begin
        check("a_frame", obs_a_q.pop_front(), exp_a_q.pop_front());
        check("a_busy_len", blen_a_q.pop_front(), blen);
      end
    end else begin
      check("b_frame_arrived", obs_b_q.size() != 0, 1);
      if (obs_b_q.size() != 0 && exp_b_q.size() != 0 && blen_b_q.size() != 0) begin
        check("b_frame", obs_b_q.pop_front(), exp_b_q.pop_front());
        check("b_busy_len", blen_b_q.pop_front(), blen);
      end
    end
  endtask

  task automatic wait_busy_a(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_busy[0] && n < 60);
    check(tag, o_busy[0], 1);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    segments = 7'h00;
    dp = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("a_reset_outs", {o_data[0], o_clk[0], o_latch[0], o_busy[0]}, 4'b0000);
    check("b_reset_outs", {o_data[1], o_clk[1], o_latch[1], o_busy[1]}, 4'b0000);

    // first frame after reset is sent even when all zero
    rst_a = 1'b0;
    exp_a_q.push_back(rec(4, 8'h00));
    @(posedge clk);
    @(negedge clk);
    check("a_busy_first_cycle", o_busy[0], 1);
    check("a_clk_low_k0", o_clk[0], 0);
    repeat (3) @(negedge clk);
    check("a_clk_low_k3", o_clk[0], 0);
    @(negedge clk);
    check("a_clk_rise_k4", o_clk[0], 1);
    check_frame(1'b0, 68);

    // changed pattern, then quiet while stable
    repeat (5) @(posedge clk);
    #1;
    segments = 7'b0111111;
    dp = 1'b1;
    exp_a_q.push_back(rec(4, 8'hBF));
    check_frame(1'b0, 68);
    repeat (15) @(negedge clk);
    check("a_quiet_busy", o_busy[0], 0);
    check("a_quiet_no_frame", obs_a_q.size(), 0);

    // periodic refresh of the unchanged frame
    gap_a_q.delete();
    for (int r = 0; r < 2; r++) begin
      exp_a_q.push_back(rec(4, 8'hBF));
      check_frame(1'b0, 68);
      check("a_refresh_gap", (gap_a_q.size() != 0) ? gap_a_q.pop_front() : -1, 20);
    end

    // input change during bit 3 of a refresh transfer
    wait_busy_a("a_refresh3_start");
    exp_a_q.push_back(rec(4, 8'hBF));
    repeat (26) @(posedge clk);
    #1;
    segments = 7'h06;
    dp = 1'b0;
    exp_a_q.push_back(rec(4, 8'h06));
    check_frame(1'b0, 68);
    check_frame(1'b0, 68);
    check("a_gap_refresh3", (gap_a_q.size() != 0) ? gap_a_q.pop_front() : -1, 20);
    check("a_gap_back_to_back", (gap_a_q.size() != 0) ? gap_a_q.pop_front() : -1, 1);

    // asynchronous reset during SHIFT_HI of bit 5
    #1;
    segments = 7'h5B;
    dp = 1'b1;
    wait_busy_a("a_db_start");
    repeat (45) @(posedge clk);
    #1;
    check("a_clk_high_bit5", o_clk[0], 1);
    rst_a = 1'b1;
    #1;
    check("a_async_reset_outs", {o_data[0], o_clk[0], o_latch[0], o_busy[0]}, 4'b0000);
    check("a_no_partial_frame", obs_a_q.size(), 0);
    exp_a_q.push_back(rec(4, 8'hDB));
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    check_frame(1'b0, 68);

    // CLK_DIV=1 instance; dut_a parked in reset
    @(posedge clk);
    #1;
    rst_a = 1'b1;
    rst_b = 1'b0;
    exp_b_q.push_back(rec(1, 8'hDB));
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("b_clk_alternate", o_clk[1], k % 2);
    end
    check_frame(1'b1, 17);
    @(posedge clk);
    #1;
    segments = 7'h4F;
    dp = 1'b0;
    exp_b_q.push_back(rec(1, 8'h4F));
    check_frame(1'b1, 17);

    // refresh disabled: nothing more from dut_b while stable
    repeat (60) @(negedge clk);
    check("b_no_refresh_frames", obs_b_q.size(), 0);
    check("b_no_refresh_busy", blen_b_q.size(), 0);
    check("a_exp_drained", exp_a_q.size(), 0);
    check("b_exp_drained", exp_b_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
